// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - command-driven strobe sequencer for the 8-bit programmable counter
//
// Purpose: accepts LOAD / STEP_UP / STEP_DOWN commands on a valid/ready port and
// produces slow, well-separated enable/clk_in/load/up_down/in levels so the
// counter's 3-stage synchronised edge detectors see every edge exactly once.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid_i       command offered
//   cmd_ready_o       idle; command accepted when cmd_valid_i & cmd_ready_o at posedge
//   cmd_op_i[1:0]     00 NOP, 01 LOAD, 10 STEP_UP, 11 STEP_DOWN
//   cmd_data_i[7:0]   LOAD value, or STEP count (0 = none)
//   busy_o            command in progress
//   done_o            one-cycle completion pulse
//   cnt_enable_o      counter enable
//   cnt_clk_in_o      counter step strobe
//   cnt_load_o        counter load strobe
//   cnt_up_down_o     counter direction (1 = up)
//   cnt_in_o[7:0]     counter load value
//   shadow_count_o    predicted counter value (0 unless shadow enabled)
//
// Configuration: define COUNTER_SEQ_SHADOW_EN to build the shadow counter.

module counter_cmd_sequencer #(
    parameter int PULSE_HI = 4,
    parameter int PULSE_LO = 4,
    parameter int SETUP    = 4,
    parameter int HOLD     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       cnt_enable_o,
    output logic       cnt_clk_in_o,
    output logic       cnt_load_o,
    output logic       cnt_up_down_o,
    output logic [7:0] cnt_in_o,
    output logic [7:0] shadow_count_o
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;

    // Timers count down from (cycles - 1) so each state lasts exactly its parameter.
    localparam logic [15:0] SETUP_T = 16'(SETUP - 1);
    localparam logic [15:0] HI_T    = 16'(PULSE_HI - 1);
    localparam logic [15:0] LO_T    = 16'(PULSE_LO - 1);
    localparam logic [15:0] HOLD_T  = 16'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [15:0] timer_q;
    logic [7:0]  remaining_q;
    logic        is_load_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        enable_q;
    logic        clk_in_q;
    logic        load_q;
    logic        up_down_q;
    logic [7:0]  cnt_in_q;
    logic        accept_w;

    assign accept_w = cmd_valid_i & cmd_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= 16'd0;
            remaining_q <= 8'd0;
            is_load_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            enable_q    <= 1'b0;
            clk_in_q    <= 1'b0;
            load_q      <= 1'b0;
            up_down_q   <= 1'b1;
            cnt_in_q    <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept_w) begin
                        if (cmd_op_i == OP_NOP) begin
                            done_q <= 1'b1;
                        end else if (cmd_op_i == OP_LOAD) begin
                            cnt_in_q    <= cmd_data_i;
                            is_load_q   <= 1'b1;
                            state_q     <= S_SETUP;
                            timer_q     <= SETUP_T;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            enable_q    <= 1'b1;
                        end else if (cmd_data_i == 8'd0) begin
                            // Zero-length step: complete without touching any counter input.
                            done_q <= 1'b1;
                        end else begin
                            remaining_q <= cmd_data_i;
                            up_down_q   <= (cmd_op_i == OP_UP);
                            is_load_q   <= 1'b0;
                            state_q     <= S_SETUP;
                            timer_q     <= SETUP_T;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            enable_q    <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (timer_q == 16'd0) begin
                        state_q <= S_HIGH;
                        timer_q <= HI_T;
                        if (is_load_q) begin
                            load_q <= 1'b1;
                        end else begin
                            clk_in_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_HIGH: begin
                    if (timer_q == 16'd0) begin
                        state_q  <= S_LOW;
                        timer_q  <= LO_T;
                        load_q   <= 1'b0;
                        clk_in_q <= 1'b0;
                        if (!is_load_q) begin
                            remaining_q <= remaining_q - 8'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_LOW: begin
                    if (timer_q == 16'd0) begin
                        if (is_load_q || remaining_q == 8'd0) begin
                            state_q <= S_HOLD;
                            timer_q <= HOLD_T;
                        end else begin
                            state_q  <= S_HIGH;
                            timer_q  <= HI_T;
                            clk_in_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (timer_q == 16'd0) begin
                        state_q     <= S_IDLE;
                        enable_q    <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cnt_enable_o  = enable_q;
    assign cnt_clk_in_o  = clk_in_q;
    assign cnt_load_o    = load_q;
    assign cnt_up_down_o = up_down_q;
    assign cnt_in_o      = cnt_in_q;

`ifdef COUNTER_SEQ_SHADOW_EN
    logic [7:0] shadow_q;
    logic       hi_entry_w;

    // Every transition into HIGH is one edge the counter will act on.
    assign hi_entry_w = (timer_q == 16'd0) &&
                        ((state_q == S_SETUP) ||
                         (state_q == S_LOW && !is_load_q && remaining_q != 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 8'h00;
        end else if (hi_entry_w) begin
            if (is_load_q) begin
                shadow_q <= cnt_in_q;
            end else if (up_down_q) begin
                shadow_q <= shadow_q + 8'd1;
            end else begin
                shadow_q <= shadow_q - 8'd1;
            end
        end
    end

    assign shadow_count_o = shadow_q;
`else
    assign shadow_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - scoreboard bench for counter_cmd_sequencer
module tb_counter_cmd_sequencer;

    localparam int HI = 4;
    localparam int LO = 4;
    localparam int SU = 4;
    localparam int HO = 4;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready_o, busy_o, done_o, cnt_enable_o, cnt_clk_in_o, cnt_load_o, cnt_up_down_o;
    logic [7:0] cnt_in_o, shadow_count_o;

    counter_cmd_sequencer #(.PULSE_HI(HI), .PULSE_LO(LO), .SETUP(SU), .HOLD(HO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
        .busy_o(busy_o), .done_o(done_o),
        .cnt_enable_o(cnt_enable_o), .cnt_clk_in_o(cnt_clk_in_o), .cnt_load_o(cnt_load_o),
        .cnt_up_down_o(cnt_up_down_o), .cnt_in_o(cnt_in_o), .shadow_count_o(shadow_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        int         lat;
        int         steps;
        int         loads;
        logic       up;
        logic       exp_ud;
        logic [7:0] exp_in;
        logic [7:0] exp_cnt;
        logic [7:0] exp_sh;
        bit         synced;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model state: what the counter and sequencer should hold after all accepted commands.
    logic [7:0] ref_cnt = 8'h00;
    logic [7:0] ref_sh  = 8'h00;
    logic [7:0] ref_in  = 8'h00;
    logic       ref_ud  = 1'b1;
    bit         synced  = 1'b0;

    // Counter model driven purely by the observed strobes.
    logic [7:0] cnt_model = 8'h00;
    int n_rise = 0, n_load = 0, hi_len = 0, lo_len = 0, ld_len = 0, en_len = 0;
    logic prev_clk = 1'b0, prev_ld = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(cmd_ready_o),    32'd0);
        chk({tag, "_busy"},   32'(busy_o),         32'd0);
        chk({tag, "_done"},   32'(done_o),         32'd0);
        chk({tag, "_enable"}, 32'(cnt_enable_o),   32'd0);
        chk({tag, "_clk_in"}, 32'(cnt_clk_in_o),   32'd0);
        chk({tag, "_load"},   32'(cnt_load_o),     32'd0);
        chk({tag, "_updown"}, 32'(cnt_up_down_o),  32'd1);
        chk({tag, "_in"},     32'(cnt_in_o),       32'd0);
        chk({tag, "_shadow"}, 32'(shadow_count_o), 32'd0);
    endtask

    task automatic clear_mon();
        n_rise = 0; n_load = 0; hi_len = 0; lo_len = 0; ld_len = 0; en_len = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        // While the sequencer is not ready, throw random traffic at it; it must be ignored.
        while (!cmd_ready_o && guard < 3000) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_data  = 8'($urandom);
            guard++;
            @(negedge clk);
        end
        if (guard >= 3000) begin
            checks++; errors++;
            $display("FAIL send_timeout: cmd_ready stuck at %0b, required 1", cmd_ready_o);
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        e.op = op; e.data = data; e.steps = 0; e.loads = 0; e.up = 1'b1; e.lat = 1;
        if (op == OP_LOAD) begin
            e.lat = SU + HI + LO + HO + 1;
            e.loads = 1;
            ref_cnt = data; ref_sh = data; ref_in = data; synced = 1'b1;
        end else if (op != OP_NOP && data != 8'd0) begin
            e.lat = SU + int'(data) * (HI + LO) + HO + 1;
            e.steps = int'(data);
            e.up = (op == OP_UP);
            ref_ud = e.up;
            ref_cnt = e.up ? ref_cnt + data : ref_cnt - data;
            ref_sh  = e.up ? ref_sh + data : ref_sh - data;
        end
        e.exp_ud = ref_ud; e.exp_in = ref_in; e.exp_cnt = ref_cnt; e.exp_sh = ref_sh;
        e.synced = synced; e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Monitor: strobe timing checks and scoreboard comparison on each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            clear_mon();
            prev_clk = 1'b0; prev_ld = 1'b0;
        end else begin
            if (cnt_clk_in_o && !prev_clk) begin
                if (n_rise == 0 && n_load == 0) chk("setup_len", 32'(en_len), 32'(SU));
                else chk("clk_low_len", 32'(lo_len), 32'(LO));
                chk("enable_at_edge", 32'(cnt_enable_o), 32'd1);
                if (sb.size() > 0) chk("updown_at_edge", 32'(cnt_up_down_o), 32'(sb[0].up));
                cnt_model = cnt_up_down_o ? cnt_model + 8'd1 : cnt_model - 8'd1;
                n_rise++;
            end
            if (!cnt_clk_in_o && prev_clk) chk("clk_high_len", 32'(hi_len), 32'(HI));
            if (cnt_load_o && !prev_ld) begin
                chk("load_setup_len", 32'(en_len), 32'(SU));
                if (sb.size() > 0) chk("in_at_load", 32'(cnt_in_o), 32'(sb[0].data));
                cnt_model = cnt_in_o;
                n_load++;
            end
            if (!cnt_load_o && prev_ld) chk("load_high_len", 32'(ld_len), 32'(HI));
            hi_len = cnt_clk_in_o ? hi_len + 1 : 0;
            lo_len = cnt_clk_in_o ? 0 : lo_len + 1;
            ld_len = cnt_load_o ? ld_len + 1 : 0;
            en_len = cnt_enable_o ? en_len + 1 : 0;
            prev_clk = cnt_clk_in_o; prev_ld = cnt_load_o;

            if (done_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: done=1 with no command outstanding");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                    chk("step_pulses", 32'(n_rise), 32'(e.steps));
                    chk("load_pulses", 32'(n_load), 32'(e.loads));
                    chk("busy_at_done", 32'(busy_o), 32'd0);
                    chk("enable_at_done", 32'(cnt_enable_o), 32'd0);
                    chk("ready_at_done", 32'(cmd_ready_o), 32'd1);
                    chk("updown_at_done", 32'(cnt_up_down_o), 32'(e.exp_ud));
                    chk("in_at_done", 32'(cnt_in_o), 32'(e.exp_in));
                    if (e.synced) chk("counter_value", 32'(cnt_model), 32'(e.exp_cnt));
`ifdef COUNTER_SEQ_SHADOW_EN
                    chk("shadow", 32'(shadow_count_o), 32'(e.exp_sh));
`else
                    chk("shadow_tied", 32'(shadow_count_o), 32'd0);
`endif
                end
                clear_mon();
            end
        end
    end

    initial begin
        int guard;
        logic [1:0] op;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready_o), 32'd1);

        // Reset in the middle of a STEP command.
        send(OP_UP, 8'd5);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        sb.delete();
        ref_sh = 8'h00; ref_in = 8'h00; ref_ud = 1'b1; synced = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_ready_low", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        chk("midrst_ready_high", 32'(cmd_ready_o), 32'd1);

        // Directed cases, including counter wrap in both directions.
        send(OP_LOAD, 8'hA5);
        send(OP_LOAD, 8'hFE);
        send(OP_UP,   8'd3);
        send(OP_LOAD, 8'h00);
        send(OP_DOWN, 8'd2);
        send(OP_UP,   8'd0);
        send(OP_NOP,  8'h5A);
        send(OP_DOWN, 8'd0);
        send(OP_NOP,  8'h00);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = (op == OP_LOAD) ? 8'($urandom) : 8'($urandom_range(0, 5));
            send(op, d);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d commands outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
